// File: rtl/adc_buf_reader_if.sv
// Valid/ready sample stream with a last marker, from the BRAM reader
// to the DMA/packetiser.
interface adc_buf_reader_if #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/adc_buf_reader.sv
// Drains a block of ADC samples from the capture BRAM read port
// and presents it as a valid/ready stream with a last flag.
module adc_buf_reader #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 16,
    parameter int MEM_SIZE = 1300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout,
    adc_buf_reader_if.master  m
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_ADDR =
        AWIDTH'(MEM_SIZE - 1);

    state_t            state_q;
    logic [AWIDTH-1:0] rd_ptr_q;
    logic [AWIDTH-1:0] rd_ptr_d;
    logic [AWIDTH-1:0] len_q;
    logic [AWIDTH-1:0] issued_q;
    logic              busy_q;
    logic              done_q;
    logic              rv_q;
    logic              rv_last_q;
    logic [DWIDTH-1:0] dat_q;
    logic              vld_q;
    logic              lst_q;
    logic [DWIDTH-1:0] sk_dat_q;
    logic              sk_vld_q;
    logic              sk_lst_q;

    logic       pop;
    logic       issue;
    logic       issue_last;
    logic [1:0] occ;

    // Occupancy counts the beat leaving this cycle as gone,
    // which is what lets a read issue every clock.
    assign pop = vld_q & m.tready;
    assign occ = 2'(rv_q) + 2'(vld_q)
               + 2'(sk_vld_q) - 2'(pop);
    assign issue = (state_q == READ) & ~abort
                 & (occ < 2'd2);
    assign issue_last = (issued_q == len_q - 1'b1);
    assign rd_ptr_d = (rd_ptr_q == LAST_ADDR)
                    ? '0 : rd_ptr_q + 1'b1;

    assign ram_ce   = issue;
    assign ram_addr = rd_ptr_q;
    assign ram_we   = 1'b0;
    assign ram_din  = '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign m.tdata  = dat_q;
    assign m.tvalid = vld_q;
    assign m.tlast  = vld_q & lst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
            rv_last_q <= 1'b0;
            dat_q     <= '0;
            vld_q     <= 1'b0;
            lst_q     <= 1'b0;
            sk_dat_q  <= '0;
            sk_vld_q  <= 1'b0;
            sk_lst_q  <= 1'b0;
        end else if (abort && state_q != IDLE) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
            vld_q    <= 1'b0;
            lst_q    <= 1'b0;
            sk_vld_q <= 1'b0;
            sk_lst_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rv_q      <= issue;
            rv_last_q <= issue & issue_last;
            if (issue) begin
                rd_ptr_q <= rd_ptr_d;
                issued_q <= issued_q + 1'b1;
            end

            // Read data is only valid on ram_dout while rv_q is set.
            if (!vld_q || m.tready) begin
                if (sk_vld_q) begin
                    dat_q    <= sk_dat_q;
                    lst_q    <= sk_lst_q;
                    vld_q    <= 1'b1;
                    sk_vld_q <= rv_q;
                    sk_dat_q <= ram_dout;
                    sk_lst_q <= rv_last_q;
                end else if (rv_q) begin
                    dat_q <= ram_dout;
                    lst_q <= rv_last_q;
                    vld_q <= 1'b1;
                end else begin
                    vld_q <= 1'b0;
                    lst_q <= 1'b0;
                end
            end else if (rv_q) begin
                sk_vld_q <= 1'b1;
                sk_dat_q <= ram_dout;
                sk_lst_q <= rv_last_q;
            end

            unique case (state_q)
                IDLE: begin
                    if (start && length != '0) begin
                        state_q  <= READ;
                        busy_q   <= 1'b1;
                        rd_ptr_q <= base_addr;
                        len_q    <= length;
                        issued_q <= '0;
                    end else if (start) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (issue && issue_last)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && lst_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_buf_reader.sv
// Scoreboard bench for adc_buf_reader with a 1300-word BRAM model
// holding RAM[i] = i + 0x100.
module tb_adc_buf_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] length = '0;
    logic        busy;
    logic        done;
    logic [15:0] ram_addr;
    logic        ram_ce;
    logic        ram_we;
    logic [15:0] ram_din;
    logic [15:0] ram_dout = '0;

    adc_buf_reader_if #(.DWIDTH(16)) m_if ();

    adc_buf_reader #(
        .DWIDTH(16),
        .AWIDTH(16),
        .MEM_SIZE(1300)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .length(length),
        .busy(busy),
        .done(done),
        .ram_addr(ram_addr),
        .ram_ce(ram_ce),
        .ram_we(ram_we),
        .ram_din(ram_din),
        .ram_dout(ram_dout),
        .m(m_if.master)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1300];
    initial begin
        for (int i = 0; i < 1300; i++)
            mem[i] = 16'(i + 'h100);
    end

    always @(posedge clk) begin
        if (ram_ce) ram_dout <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int beats = 0;
    int done_cnt = 0;
    bit ce_seen = 0;
    bit tv_seen = 0;
    logic [16:0] exp_q [$];

    function automatic void chk(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endfunction

    bit          sv_pend = 0;
    logic [15:0] sv_data;
    logic        sv_last;
    always @(negedge clk) begin
        if (rst) begin
            sv_pend = 0;
        end else begin
            if (ram_ce) begin
                ce_seen = 1;
                chk("ram_we", 32'(ram_we), 0);
                chk("ram_din", 32'(ram_din), 0);
            end
            if (m_if.tvalid) tv_seen = 1;
            if (done) done_cnt++;
            if (sv_pend) begin
                chk("stall_valid", 32'(m_if.tvalid), 1);
                chk("stall_data", 32'(m_if.tdata),
                    32'(sv_data));
                chk("stall_last", 32'(m_if.tlast),
                    32'(sv_last));
            end
            sv_pend = m_if.tvalid && !m_if.tready && !abort;
            sv_data = m_if.tdata;
            sv_last = m_if.tlast;
            if (m_if.tvalid && m_if.tready && !abort) begin
                logic [16:0] e;
                beats++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(m_if.tdata), 32'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(m_if.tdata),
                        32'(e[15:0]));
                    chk("beat_last", 32'(m_if.tlast),
                        32'(e[16]));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b,
                            input logic [15:0] l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        length = l;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] w0,
                        input int n,
                        input int len);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == len - 1),
                             16'(w0 + 16'(i))});
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy ||
                m_if.tvalid) && n < 300) begin
            cyc(1);
            n++;
        end
        chk(nm, 32'(n < 300), 1);
    endtask

    initial begin
        int d0;
        int b0;
        m_if.tready = 1'b1;
        cyc(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ce", 32'(ram_ce), 0);
        chk("rst_tvalid", 32'(m_if.tvalid), 0);
        chk("rst_tlast", 32'(m_if.tlast), 0);
        chk("rst_tdata", 32'(m_if.tdata), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        rst = 1'b0;
        cyc(2);

        // 1: back-to-back stream and latency
        push(16'h100, 4, 4);
        d0 = done_cnt;
        do_start(16'd0, 16'd4);
        chk("t1_busy", 32'(busy), 1);
        cyc(1);
        chk("t1_early", 32'(m_if.tvalid), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t1_valid", 32'(m_if.tvalid), 1);
            chk("t1_last", 32'(m_if.tlast),
                32'(i == 3));
        end
        cyc(1);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_valid_off", 32'(m_if.tvalid), 0);
        cyc(1);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_done_cnt", 32'(done_cnt - d0), 1);

        // 2: address wrap
        exp_q.push_back({1'b0, 16'h612});
        exp_q.push_back({1'b0, 16'h613});
        exp_q.push_back({1'b0, 16'h100});
        exp_q.push_back({1'b1, 16'h101});
        do_start(16'd1298, 16'd4);
        wait_idle("t2_idle");
        cyc(3);

        // 3: backpressure with a long stall
        push(16'h164, 8, 8);
        do_start(16'd100, 16'd8);
        for (int c = 0; c < 40; c++) begin
            m_if.tready = (c >= 8 && c < 13) ? 1'b0
                        : 1'(c & 1);
            cyc(1);
        end
        m_if.tready = 1'b1;
        wait_idle("t3_idle");
        cyc(3);

        // 4: zero length
        ce_seen = 0;
        tv_seen = 0;
        d0 = done_cnt;
        do_start(16'd7, 16'd0);
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        cyc(5);
        chk("t4_ce", 32'(ce_seen), 0);
        chk("t4_tvalid", 32'(tv_seen), 0);
        chk("t4_done_cnt", 32'(done_cnt - d0), 1);

        // 5: abort on third beat, then a clean run
        push(16'h1c8, 2, 10);
        d0 = done_cnt;
        do_start(16'd200, 16'd10);
        cyc(4);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t5_tvalid", 32'(m_if.tvalid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ce", 32'(ram_ce), 0);
        cyc(4);
        chk("t5_no_done", 32'(done_cnt - d0), 0);
        chk("t5_q", 32'(exp_q.size()), 0);
        push(16'h2f4, 2, 2);
        do_start(16'd500, 16'd2);
        wait_idle("t5_idle");
        cyc(3);
        chk("t5_done_cnt", 32'(done_cnt - d0), 1);

        // 6: async reset mid-burst
        exp_q.push_back({1'b0, 16'h114});
        d0 = done_cnt;
        do_start(16'd20, 16'd20);
        cyc(3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_tvalid", 32'(m_if.tvalid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ce", 32'(ram_ce), 0);
        chk("t6_tdata", 32'(m_if.tdata), 0);
        chk("t6_tlast", 32'(m_if.tlast), 0);
        cyc(1);
        rst = 1'b0;
        tv_seen = 0;
        cyc(6);
        chk("t6_no_beat", 32'(tv_seen), 0);
        chk("t6_q", 32'(exp_q.size()), 0);
        chk("t6_no_done", 32'(done_cnt - d0), 0);

        // start while busy is ignored
        push(16'h10a, 3, 3);
        b0 = beats;
        d0 = done_cnt;
        do_start(16'd10, 16'd3);
        start = 1'b1;
        base_addr = 16'd50;
        length = 16'd9;
        cyc(1);
        start = 1'b0;
        wait_idle("t6_idle");
        cyc(5);
        chk("t6_beats", 32'(beats - b0), 3);
        chk("t6_done_cnt", 32'(done_cnt - d0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
